axis_rr_combiner: RTL and testbench

- N-channel AXI-stream combiner: merges N_CHANNELS axi_stream slave inputs onto one axi_stream master output using round-robin arbitration.
- Each input has a 2-entry skid buffer, so input ready is registered and there is no combinational path from input ready to output ready.
- Optional packet-locked arbitration on tlast and optional dest tagging with the source channel index.
- Sits between multiple data producers (ADC front-ends, scope channels) and a single stream consumer (DMA, scope packer).

---
 rtl/axis_rr_combiner.sv | 123 ++++++++++++
 tb/tb_axis_rr_combiner.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_combiner.sv
// axis_rr_combiner: round-robin merge of N AXI-stream inputs, each behind a 2-entry skid buffer,
// onto one registered output with optional packet-locked arbitration and source dest tagging.
module axis_rr_combiner #(
    parameter int N_CHANNELS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32,
    parameter int DEST_WIDTH = 32,
    parameter int PACKET_MODE = 0,
    parameter int TAG_DEST = 0,
    localparam int CW = N_CHANNELS > 1 ? $clog2(N_CHANNELS) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] stream_in_data,
    input  logic [N_CHANNELS*USER_WIDTH-1:0] stream_in_user,
    input  logic [N_CHANNELS*DEST_WIDTH-1:0] stream_in_dest,
    input  logic [N_CHANNELS-1:0]            stream_in_valid,
    input  logic [N_CHANNELS-1:0]            stream_in_tlast,
    output logic [N_CHANNELS-1:0]            stream_in_ready,
    output logic [DATA_WIDTH-1:0]            stream_out_data,
    output logic [USER_WIDTH-1:0]            stream_out_user,
    output logic [DEST_WIDTH-1:0]            stream_out_dest,
    output logic                             stream_out_valid,
    output logic                             stream_out_tlast,
    input  logic                             stream_out_ready,
    output logic [CW-1:0]                    grant_channel,
    output logic                             packet_lock
);
    localparam int BW = DATA_WIDTH + USER_WIDTH + DEST_WIDTH + 1;

    logic [BW-1:0] mem [N_CHANNELS][2];
    logic [N_CHANNELS-1:0][1:0] count, count_nxt;
    logic [N_CHANNELS-1:0] rd_ptr, wr_ptr, push, pop, eligible;
    logic [N_CHANNELS-1:0][BW-1:0] head;
    logic [CW-1:0] rr_ptr, winner, lock_ch;
    logic [BW-1:0] win_beat;
    logic [DEST_WIDTH-1:0] win_dest;
    logic found, load;

    assign load = !stream_out_valid || stream_out_ready;
    assign win_beat = head[winner];
    assign win_dest = TAG_DEST != 0 ? DEST_WIDTH'(winner) : win_beat[DEST_WIDTH:1];

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            head[i] = mem[i][rd_ptr[i]];
            push[i] = stream_in_valid[i] && stream_in_ready[i];
            eligible[i] = count[i] != 2'd0 && (PACKET_MODE == 0 || !packet_lock || lock_ch == CW'(i));
        end
    end

    // first eligible channel after the last winner
    always_comb begin
        found = 1'b0;
        winner = '0;
        for (int k = 1; k <= N_CHANNELS; k++) begin
            if (!found && eligible[(int'(rr_ptr) + k) % N_CHANNELS]) begin
                found = 1'b1;
                winner = CW'((int'(rr_ptr) + k) % N_CHANNELS);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            pop[i] = load && found && winner == CW'(i);
            count_nxt[i] = count[i] + 2'(push[i]) - 2'(pop[i]);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CHANNELS; i++)
            if (push[i])
                mem[i][wr_ptr[i]] <= {stream_in_data[i*DATA_WIDTH +: DATA_WIDTH],
                                      stream_in_user[i*USER_WIDTH +: USER_WIDTH],
                                      stream_in_dest[i*DEST_WIDTH +: DEST_WIDTH],
                                      stream_in_tlast[i]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            stream_in_ready <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                count[i] <= count_nxt[i];
                stream_in_ready[i] <= count_nxt[i] != 2'd2;
                if (push[i])
                    wr_ptr[i] <= !wr_ptr[i];
                if (pop[i])
                    rd_ptr[i] <= !rd_ptr[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stream_out_valid <= 1'b0;
            stream_out_data <= '0;
            stream_out_user <= '0;
            stream_out_dest <= '0;
            stream_out_tlast <= 1'b0;
            grant_channel <= '0;
            rr_ptr <= CW'(N_CHANNELS - 1);
            packet_lock <= 1'b0;
            lock_ch <= '0;
        end else if (load) begin
            stream_out_valid <= found;
            if (found) begin
                stream_out_data <= win_beat[BW-1 -: DATA_WIDTH];
                stream_out_user <= win_beat[DEST_WIDTH + USER_WIDTH -: USER_WIDTH];
                stream_out_dest <= win_dest;
                stream_out_tlast <= win_beat[0];
                grant_channel <= winner;
                rr_ptr <= winner;
                packet_lock <= PACKET_MODE != 0 && !win_beat[0];
                lock_ch <= winner;
            end
        end
    end
endmodule

// File: tb/tb_axis_rr_combiner.sv
// tb_axis_rr_combiner: directed and randomized scoreboard bench for a plain
// combiner (dut_a) and a packet-locked, dest-tagging combiner (dut_b).
module tb_axis_rr_combiner;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] user;
        logic [31:0] dest;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    beat_t cur [2][4];
    beat_t src_q [2][4][$];
    beat_t exp_q [2][4][$];
    int glog [2][$];
    int tlog [2][$];
    int p [2];
    int rprob [2];
    int cyc, n_chk, n_pass;
    bit saw_lock, tag_done;

    logic [1:0][3:0] vin, rdy, acc, ilast;
    logic [1:0] ordy, o_valid, o_last, o_lock, stall, in_pkt;
    logic [1:0][31:0] o_data, o_user;
    logic [1:0][1:0] o_grant, pkt_ch;
    logic [1:0][98:0] held;
    logic [127:0] a_idata, a_iuser, a_idest, b_idata, b_iuser;
    logic [31:0] b_idest, a_odest;
    logic [7:0] b_odest;

    for (genvar g = 0; g < 4; g++) begin : pk
        assign a_idata[g*32 +: 32] = cur[0][g].data;
        assign a_iuser[g*32 +: 32] = cur[0][g].user;
        assign a_idest[g*32 +: 32] = cur[0][g].dest;
        assign b_idata[g*32 +: 32] = cur[1][g].data;
        assign b_iuser[g*32 +: 32] = cur[1][g].user;
        assign b_idest[g*8 +: 8] = cur[1][g].dest[7:0];
        assign ilast[0][g] = cur[0][g].last;
        assign ilast[1][g] = cur[1][g].last;
    end

    axis_rr_combiner dut_a (
        .clock(clock), .reset(reset),
        .stream_in_data(a_idata), .stream_in_user(a_iuser), .stream_in_dest(a_idest),
        .stream_in_valid(vin[0]), .stream_in_tlast(ilast[0]), .stream_in_ready(rdy[0]),
        .stream_out_data(o_data[0]), .stream_out_user(o_user[0]), .stream_out_dest(a_odest),
        .stream_out_valid(o_valid[0]), .stream_out_tlast(o_last[0]), .stream_out_ready(ordy[0]),
        .grant_channel(o_grant[0]), .packet_lock(o_lock[0])
    );

    axis_rr_combiner #(.DEST_WIDTH(8), .PACKET_MODE(1), .TAG_DEST(1)) dut_b (
        .clock(clock), .reset(reset),
        .stream_in_data(b_idata), .stream_in_user(b_iuser), .stream_in_dest(b_idest),
        .stream_in_valid(vin[1]), .stream_in_tlast(ilast[1]), .stream_in_ready(rdy[1]),
        .stream_out_data(o_data[1]), .stream_out_user(o_user[1]), .stream_out_dest(b_odest),
        .stream_out_valid(o_valid[1]), .stream_out_tlast(o_last[1]), .stream_out_ready(ordy[1]),
        .grant_channel(o_grant[1]), .packet_lock(o_lock[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] odest(input int d);
        return d != 0 ? {24'h0, b_odest} : a_odest;
    endfunction

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        b.data = $urandom;
        b.user = $urandom;
        b.dest = $urandom;
        b.last = last;
        return b;
    endfunction

    function automatic bit busy();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
                if (src_q[d][c].size() != 0 || exp_q[d][c].size() != 0 || vin[d][c])
                    return 1'b1;
        return |o_valid;
    endfunction

    task automatic drv(input int d);
        for (int c = 0; c < 4; c++) begin
            if (acc[d][c]) begin
                vin[d][c] = 1'b0;
                acc[d][c] = 1'b0;
            end
            if (!vin[d][c] && src_q[d][c].size() != 0 && $urandom_range(99) < p[d]) begin
                cur[d][c] = src_q[d][c][0];
                vin[d][c] = 1'b1;
            end
        end
    endtask

    // Evaluates what the coming rising edge will do, from pre-edge values.
    task automatic mon(input int d);
        beat_t e;
        int c, occ;
        if (stall[d])
            chk("stable", {o_valid[d], o_data[d], o_user[d], odest(d), o_last[d], o_grant[d]}, {1'b1, held[d]});
        for (int k = 0; k < 4; k++) begin
            occ = exp_q[d][k].size() - ((o_valid[d] && o_grant[d] == 2'(k)) ? 1 : 0);
            chk("ready", rdy[d][k], occ < 2);
        end
        chk("lock", o_lock[d], d != 0 ? (o_valid[d] ? !o_last[d] : in_pkt[d]) : 1'b0);
        if (o_valid[d] && ordy[d]) begin
            c = int'(o_grant[d]);
            if (d != 0 && in_pkt[d])
                chk("pkt_hold", o_grant[d], pkt_ch[d]);
            chk("avail", exp_q[d][c].size() != 0, 1'b1);
            if (exp_q[d][c].size() != 0) begin
                e = exp_q[d][c].pop_front();
                if (d != 0)
                    e.dest = 32'(c);
                chk("beat", {o_data[d], o_user[d], odest(d), o_last[d]}, e);
            end
            in_pkt[d] = !o_last[d];
            pkt_ch[d] = o_grant[d];
            glog[d].push_back(c);
            tlog[d].push_back(cyc);
        end
        stall[d] = o_valid[d] && !ordy[d];
        held[d] = {o_data[d], o_user[d], odest(d), o_last[d], o_grant[d]};
        for (int k = 0; k < 4; k++)
            if (vin[d][k] && rdy[d][k]) begin
                exp_q[d][k].push_back(cur[d][k]);
                void'(src_q[d][k].pop_front());
                acc[d][k] = 1'b1;
            end
    endtask

    task automatic cycle();
        for (int d = 0; d < 2; d++) begin
            ordy[d] = $urandom_range(99) < rprob[d];
            drv(d);
        end
        for (int d = 0; d < 2; d++)
            mon(d);
        @(negedge clock);
        cyc++;
        if (o_lock[1])
            saw_lock = 1'b1;
        if (!tag_done && o_valid[1] && o_grant[1] == 2'd3) begin
            chk("dest_tag", b_odest, 8'h03);
            tag_done = 1'b1;
        end
    endtask

    task automatic drain();
        p[0] = 100;
        p[1] = 100;
        rprob[0] = 100;
        rprob[1] = 100;
        for (int k = 0; k < 400 && busy(); k++)
            cycle();
        chk("drain", busy(), 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", o_valid[d], 1'b0);
            chk("rst_lock", o_lock[d], 1'b0);
            chk("rst_grant", o_grant[d], 2'd0);
            chk("rst_ready", rdy[d], 4'h0);
            for (int c = 0; c < 4; c++) begin
                src_q[d][c].delete();
                exp_q[d][c].delete();
            end
        end
        vin = '0;
        acc = '0;
        stall = '0;
        in_pkt = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++)
            chk("ready_after_rst", rdy[d], 4'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int first, last, cnt;
        bit saw_full;
        cyc = 0;
        n_chk = 0;
        n_pass = 0;
        saw_lock = 1'b0;
        tag_done = 1'b0;
        vin = '0;
        acc = '0;
        ordy = '1;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
                cur[d][c] = '0;
        p[0] = 100;
        p[1] = 100;
        rprob[0] = 100;
        rprob[1] = 100;
        @(negedge clock);
        do_reset();

        b = '{32'hA5A5_0002, 32'h0000_0011, 32'd7, 1'b1};
        src_q[0][2].push_back(b);
        cycle();
        chk("single_idle", o_valid[0], 1'b0);
        cycle();
        chk("single_valid", o_valid[0], 1'b1);
        chk("single_data", o_data[0], 32'hA5A5_0002);
        chk("single_dest", a_odest, 32'd7);
        chk("single_grant", o_grant[0], 2'd2);
        drain();

        do_reset();
        glog[0].delete();
        tlog[0].delete();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 30; i++)
                src_q[0][c].push_back('{32'(c << 16 | i), 32'(i), 32'(c), 1'b1});
        drain();
        chk("rr_total", glog[0].size(), 120);
        for (int i = 0; i < 100; i++)
            chk("rr_order", glog[0][i], i % 4);
        chk("rr_span", tlog[0][99] - tlog[0][0], 99);

        glog[0].delete();
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++)
            src_q[0][0].push_back('{32'(i), 32'(i), 32'(i), 1'b1});
        for (int k = 0; k < 40; k++) begin
            rprob[0] = (k >= 5 && k <= 9) ? 0 : 100;
            cycle();
            if (!rdy[0][0])
                saw_full = 1'b1;
        end
        drain();
        chk("bp_full", saw_full, 1'b1);
        chk("bp_count", glog[0].size(), 20);

        do_reset();
        glog[1].delete();
        src_q[1][1].push_back('{32'h1000, 32'h0, 32'h0, 1'b0});
        src_q[1][1].push_back('{32'h1001, 32'h0, 32'h0, 1'b0});
        for (int i = 0; i < 12; i++)
            src_q[1][3].push_back('{32'(32'h3000 + i), 32'h0, 32'hFF, 1'b1});
        for (int k = 0; k < 20 && (src_q[1][1].size() != 0 || vin[1][1]); k++)
            cycle();
        repeat (3) cycle();
        src_q[1][1].push_back('{32'h1002, 32'h0, 32'h0, 1'b0});
        src_q[1][1].push_back('{32'h1003, 32'h0, 32'h0, 1'b1});
        drain();
        first = -1;
        last = -1;
        cnt = 0;
        foreach (glog[1][i])
            if (glog[1][i] == 1) begin
                if (first < 0)
                    first = i;
                last = i;
                cnt++;
            end
        chk("pkt_count", cnt, 4);
        chk("pkt_contig", last - first, 3);
        chk("pkt_saw_lock", saw_lock, 1'b1);
        chk("tag_seen", tag_done, 1'b1);

        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 20; i++)
                    src_q[d][c].push_back(rnd_beat(d == 0 ? 1'($urandom_range(1)) : (i == 19 || $urandom_range(2) == 0)));
        p[0] = 60;
        p[1] = 60;
        rprob[0] = 70;
        rprob[1] = 70;
        repeat (300) cycle();
        drain();

        p[0] = 100;
        rprob[0] = 0;
        rprob[1] = 0;
        for (int i = 0; i < 4; i++)
            src_q[0][2].push_back(rnd_beat(1'b1));
        repeat (6) cycle();
        chk("pre_rst_full", rdy[0][2], 1'b0);
        chk("pre_rst_valid", o_valid[0], 1'b1);
        chk("pre_rst_grant", o_grant[0], 2'd2);
        do_reset();
        glog[0].delete();
        src_q[0][3].push_back(rnd_beat(1'b1));
        src_q[0][0].push_back(rnd_beat(1'b1));
        drain();
        chk("post_rst_count", glog[0].size(), 2);
        chk("post_rst_first", glog[0].size() != 0 ? glog[0][0] : -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
